// File: rtl/lateral_inhibition_kwta.sv
// k-winner-take-all lateral inhibition over one gamma window.
// Admits the first K spiking neurons (ties broken by index priority),
// records index/time per winner slot, inhibits all later spikes.
module lateral_inhibition_kwta #(
  parameter int NUM_NEURONS = 8,
  parameter int TIME_PERIOD = 8,
  parameter int K           = 1,
  parameter int TIE_HIGH    = 0,
  localparam int IW = $clog2(NUM_NEURONS),
  localparam int TW = $clog2(TIME_PERIOD),
  localparam int CW = $clog2(K+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gamma_start,
  input  logic [NUM_NEURONS-1:0] spike_volley,
  output logic [NUM_NEURONS-1:0] out_spikes,
  output logic [NUM_NEURONS-1:0] winner_mask,
  output logic [K*IW-1:0]        winner_idx,
  output logic [K*TW-1:0]        winner_time,
  output logic [CW-1:0]          winner_count,
  output logic [TW-1:0]          time_val,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                      state_q, state_d;
  logic [NUM_NEURONS-1:0]      out_q, out_d, mask_q, mask_d;
  logic [K-1:0][IW-1:0]        idx_q, idx_d, adm_idx;
  logic [K-1:0][TW-1:0]        wt_q, wt_d, adm_wt;
  logic [CW-1:0]               cnt_q, cnt_d, adm_cnt;
  logic [TW-1:0]               time_q, time_d;
  logic                        done_q, done_d;
  logic                        last;

  // cand is viewed in priority order (cand_o[0] = highest priority),
  // admissions are mapped back to neuron order with the same permutation
  logic [NUM_NEURONS-1:0]      cand, cand_o, adm_o, adm;

  assign cand = spike_volley & ~mask_q;
  assign last = (time_q == TW'(TIME_PERIOD-1));

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_order
    assign cand_o[g] = (TIE_HIGH != 0) ? cand[NUM_NEURONS-1-g]  : cand[g];
    assign adm[g]    = (TIE_HIGH != 0) ? adm_o[NUM_NEURONS-1-g] : adm_o[g];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: gamma_start always (re)opens a window
  always_comb begin
    state_d = state_q;
    if (gamma_start)                   state_d = COLLECT;
    else if (state_q == COLLECT && last) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == COLLECT);
  end

  // Admit up to the free slot count in priority order, filling slots in turn
  always_comb begin
    int slot;
    slot    = int'(cnt_q);
    adm_o   = '0;
    adm_idx = idx_q;
    adm_wt  = wt_q;
    for (int p = 0; p < NUM_NEURONS; p++) begin
      if (cand_o[p] && slot < K) begin
        adm_o[p] = 1'b1;
        for (int s = 0; s < K; s++) begin
          if (s == slot) begin
            adm_idx[s] = (TIE_HIGH != 0) ? IW'(NUM_NEURONS-1-p) : IW'(p);
            adm_wt[s]  = time_q;
          end
        end
        slot = slot + 1;
      end
    end
    adm_cnt = CW'(slot);
  end

  // Result/next-state selection: clear on start, accumulate while collecting
  always_comb begin
    out_d  = '0;
    mask_d = mask_q;
    idx_d  = idx_q;
    wt_d   = wt_q;
    cnt_d  = cnt_q;
    time_d = time_q;
    done_d = 1'b0;
    if (gamma_start) begin
      mask_d = '0;
      idx_d  = '0;
      wt_d   = '0;
      cnt_d  = '0;
      time_d = '0;
    end else if (state_q == COLLECT) begin
      out_d  = adm;
      mask_d = mask_q | adm;
      idx_d  = adm_idx;
      wt_d   = adm_wt;
      cnt_d  = adm_cnt;
      // time holds at its final value once the window closes
      if (last) done_d = 1'b1;
      else      time_d = time_q + 1'b1;
    end
  end

  // Result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
      wt_q   <= '0;
      cnt_q  <= '0;
      time_q <= '0;
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      wt_q   <= wt_d;
      cnt_q  <= cnt_d;
      time_q <= time_d;
      done_q <= done_d;
    end
  end

  assign out_spikes   = out_q;
  assign winner_mask  = mask_q;
  assign winner_idx   = idx_q;
  assign winner_time  = wt_q;
  assign winner_count = cnt_q;
  assign time_val     = time_q;
  assign done         = done_q;

endmodule
